// File: rtl/exception_controller_if.sv
// Bundle between the exception sequencer and the datapath/memory around it.
// master is the sequencer's view; slave is the datapath/memory view.
interface exception_controller_if;
    logic        excOpcode;
    logic        excOverflow;
    logic        excDivZero;
    logic [31:0] pcCurrent;
    logic [7:0]  memData;
    logic [1:0]  causeSel;
    logic        causeWrite;
    logic        epcWrite;
    logic [31:0] epcValue;
    logic        memRead;
    logic [31:0] memAddr;
    logic        pcWrite;
    logic [31:0] pcValue;
    logic        busy;

    modport master (
        input  excOpcode, excOverflow, excDivZero, pcCurrent, memData,
        output causeSel, causeWrite, epcWrite, epcValue, memRead, memAddr,
               pcWrite, pcValue, busy
    );

    modport slave (
        output excOpcode, excOverflow, excDivZero, pcCurrent, memData,
        input  causeSel, causeWrite, epcWrite, epcValue, memRead, memAddr,
               pcWrite, pcValue, busy
    );
endinterface

// File: rtl/exception_controller.sv
// Exception entry sequencer: saves Cause/EPC, fetches the handler vector byte, loads PC.
// Busy for 2+MEM_LATENCY cycles after the flag edge; flags are ignored while busy.
module exception_controller #(
    parameter int MEM_LATENCY  = 1,
    parameter int VEC_OPCODE   = 253,
    parameter int VEC_OVERFLOW = 254,
    parameter int VEC_DIVZERO  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    exception_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_WAIT,
        ST_LOAD
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      r_state,     w_state;
    logic [1:0]  r_cause_sel, w_cause_sel;
    logic        r_cause_wr,  w_cause_wr;
    logic        r_epc_wr,    w_epc_wr;
    logic [31:0] r_epc_val,   w_epc_val;
    logic        r_mem_rd,    w_mem_rd;
    logic [31:0] r_mem_addr,  w_mem_addr;
    logic        r_pc_wr,     w_pc_wr;
    logic [31:0] r_pc_val,    w_pc_val;
    logic        r_busy,      w_busy;
    logic [2:0]  r_cnt,       w_cnt;
    logic        w_any_exc;

    assign bus.causeSel   = r_cause_sel;
    assign bus.causeWrite = r_cause_wr;
    assign bus.epcWrite   = r_epc_wr;
    assign bus.epcValue   = r_epc_val;
    assign bus.memRead    = r_mem_rd;
    assign bus.memAddr    = r_mem_addr;
    assign bus.pcWrite    = r_pc_wr;
    assign bus.pcValue    = r_pc_val;
    assign bus.busy       = r_busy;

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        w_any_exc   = bus.excOpcode | bus.excOverflow | bus.excDivZero;
        w_state     = r_state;
        w_cause_sel = r_cause_sel;
        w_cause_wr  = 1'b0;
        w_epc_wr    = 1'b0;
        w_epc_val   = r_epc_val;
        w_mem_rd    = 1'b0;
        w_mem_addr  = 32'd0;
        w_pc_wr     = 1'b0;
        w_pc_val    = 32'd0;
        w_busy      = 1'b0;
        w_cnt       = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any_exc) begin
                    w_state    = ST_SAVE;
                    w_cause_wr = 1'b1;
                    w_epc_wr   = 1'b1;
                    w_epc_val  = bus.pcCurrent - 32'd4;
                    w_mem_rd   = 1'b1;
                    w_busy     = 1'b1;
                    if (bus.excOpcode) begin
                        w_cause_sel = 2'b00;
                        w_mem_addr  = 32'(VEC_OPCODE);
                    end else if (bus.excOverflow) begin
                        w_cause_sel = 2'b01;
                        w_mem_addr  = 32'(VEC_OVERFLOW);
                    end else begin
                        w_cause_sel = 2'b10;
                        w_mem_addr  = 32'(VEC_DIVZERO);
                    end
                end
            end
            ST_SAVE: begin
                w_state    = ST_WAIT;
                w_cnt      = LAT;
                w_mem_rd   = 1'b1;
                w_mem_addr = r_mem_addr;
                w_busy     = 1'b1;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (r_cnt <= 3'd1) begin
                    // Last wait cycle: memData is valid at this edge.
                    w_state  = ST_LOAD;
                    w_cnt    = 3'd0;
                    w_pc_wr  = 1'b1;
                    w_pc_val = {24'd0, bus.memData};
                end else begin
                    w_cnt      = r_cnt - 3'd1;
                    w_mem_rd   = 1'b1;
                    w_mem_addr = r_mem_addr;
                end
            end
            ST_LOAD: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cause_sel <= 2'b00;
            r_cause_wr  <= 1'b0;
            r_epc_wr    <= 1'b0;
            r_epc_val   <= 32'd0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_pc_wr     <= 1'b0;
            r_pc_val    <= 32'd0;
            r_busy      <= 1'b0;
            r_cnt       <= 3'd0;
        end else begin
            r_state     <= w_state;
            r_cause_sel <= w_cause_sel;
            r_cause_wr  <= w_cause_wr;
            r_epc_wr    <= w_epc_wr;
            r_epc_val   <= w_epc_val;
            r_mem_rd    <= w_mem_rd;
            r_mem_addr  <= w_mem_addr;
            r_pc_wr     <= w_pc_wr;
            r_pc_val    <= w_pc_val;
            r_busy      <= w_busy;
            r_cnt       <= w_cnt;
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: two instances (memory latency 1 and 3) driven by
// directed scenarios then random flags/data/resets, checked against a sequence-position model.
module tb_exception_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exception_controller_if if_l1 ();
    exception_controller_if if_l3 ();

    exception_controller #(.MEM_LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(if_l1));
    exception_controller #(.MEM_LATENCY(3)) u_dut_l3 (.clk(clk), .reset(reset), .bus(if_l3));

    logic        t_op [2];
    logic        t_ov [2];
    logic        t_dz [2];
    logic [31:0] t_pc [2];
    logic [7:0]  t_md [2];

    assign if_l1.excOpcode   = t_op[0];
    assign if_l1.excOverflow = t_ov[0];
    assign if_l1.excDivZero  = t_dz[0];
    assign if_l1.pcCurrent   = t_pc[0];
    assign if_l1.memData     = t_md[0];
    assign if_l3.excOpcode   = t_op[1];
    assign if_l3.excOverflow = t_ov[1];
    assign if_l3.excDivZero  = t_dz[1];
    assign if_l3.pcCurrent   = t_pc[1];
    assign if_l3.memData     = t_md[1];

    logic [1:0]  o_csel  [2];
    logic        o_cw    [2];
    logic        o_ew    [2];
    logic [31:0] o_epc   [2];
    logic        o_rd    [2];
    logic [31:0] o_addr  [2];
    logic        o_pw    [2];
    logic [31:0] o_pcval [2];
    logic        o_busy  [2];

    assign o_csel[0]  = if_l1.causeSel;   assign o_csel[1]  = if_l3.causeSel;
    assign o_cw[0]    = if_l1.causeWrite; assign o_cw[1]    = if_l3.causeWrite;
    assign o_ew[0]    = if_l1.epcWrite;   assign o_ew[1]    = if_l3.epcWrite;
    assign o_epc[0]   = if_l1.epcValue;   assign o_epc[1]   = if_l3.epcValue;
    assign o_rd[0]    = if_l1.memRead;    assign o_rd[1]    = if_l3.memRead;
    assign o_addr[0]  = if_l1.memAddr;    assign o_addr[1]  = if_l3.memAddr;
    assign o_pw[0]    = if_l1.pcWrite;    assign o_pw[1]    = if_l3.pcWrite;
    assign o_pcval[0] = if_l1.pcValue;    assign o_pcval[1] = if_l3.pcValue;
    assign o_busy[0]  = if_l1.busy;       assign o_busy[1]  = if_l3.busy;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Model: m_k is the cycle position inside an exception sequence (0 = idle,
    // 1 = save cycle, 2..1+L = waiting, 2+L = PC load).
    int          m_k    [2] = '{0, 0};
    int          m_nexc [2] = '{0, 0};
    logic [1:0]  m_csel [2] = '{2'b00, 2'b00};
    logic [31:0] m_epc  [2];
    logic [31:0] m_vec  [2];
    logic [7:0]  m_data [2];
    int          ob_cw  [2] = '{0, 0};
    int          ob_pw  [2] = '{0, 0};

    always @(posedge clk or negedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_k[d]    <= 0;
                m_csel[d] <= 2'b00;
            end else if (m_k[d] == 0) begin
                if (t_op[d] || t_ov[d] || t_dz[d]) begin
                    m_k[d]    <= 1;
                    m_nexc[d] <= m_nexc[d] + 1;
                    m_epc[d]  <= t_pc[d] - 32'd4;
                    if (t_op[d]) begin
                        m_csel[d] <= 2'd0; m_vec[d] <= 32'd253;
                    end else if (t_ov[d]) begin
                        m_csel[d] <= 2'd1; m_vec[d] <= 32'd254;
                    end else begin
                        m_csel[d] <= 2'd2; m_vec[d] <= 32'd255;
                    end
                end
            end else if (m_k[d] == 1 + lat(d)) begin
                m_data[d] <= t_md[d];
                m_k[d]    <= m_k[d] + 1;
            end else if (m_k[d] == 2 + lat(d)) begin
                m_k[d] <= 0;
            end else begin
                m_k[d] <= m_k[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_busy", d), 32'(o_busy[d]), 32'(m_k[d] != 0));
            chk($sformatf("d%0d_causeWrite", d), 32'(o_cw[d]), 32'(m_k[d] == 1));
            chk($sformatf("d%0d_epcWrite", d), 32'(o_ew[d]), 32'(m_k[d] == 1));
            chk($sformatf("d%0d_memRead", d), 32'(o_rd[d]),
                32'(m_k[d] >= 1 && m_k[d] <= 1 + lat(d)));
            chk($sformatf("d%0d_pcWrite", d), 32'(o_pw[d]), 32'(m_k[d] == 2 + lat(d)));
            chk($sformatf("d%0d_causeSel", d), 32'(o_csel[d]), 32'(m_csel[d]));
            if (m_k[d] == 0) begin
                chk($sformatf("d%0d_idle_memAddr", d), o_addr[d], 32'd0);
                chk($sformatf("d%0d_idle_pcValue", d), o_pcval[d], 32'd0);
            end else if (m_k[d] <= 1 + lat(d)) begin
                chk($sformatf("d%0d_memAddr", d), o_addr[d], m_vec[d]);
            end else begin
                chk($sformatf("d%0d_pcValue", d), o_pcval[d], {24'd0, m_data[d]});
            end
            if (m_k[d] == 1)
                chk($sformatf("d%0d_epcValue", d), o_epc[d], m_epc[d]);
            if (o_cw[d]) ob_cw[d]++;
            if (o_pw[d]) ob_pw[d]++;
        end
    end

    int         bcnt;
    int         snap;
    logic [2:0] f;

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_op[d] = 1'b0; t_ov[d] = 1'b1; t_dz[d] = 1'b0;
        end
        t_pc[0] = 32'h0000_0040; t_md[0] = 8'h7C;
        t_pc[1] = 32'h0000_0100; t_md[1] = 8'h11;

        // Reset held for three edges with a flag pending.
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(o_busy[0]), 32'd0);
        chk("rst_memRead",  32'(o_rd[0]),   32'd0);
        chk("rst_causeSel", 32'(o_csel[0]), 32'd0);
        chk("rst_epcValue", o_epc[0],       32'd0);
        chk("rst_memAddr",  o_addr[0],      32'd0);
        chk("rst_pcValue",  o_pcval[0],     32'd0);
        #1 reset = 1'b1;

        // Single overflow, latency 1.
        @(negedge clk);
        chk("ovf_causeSel", 32'(o_csel[0]), 32'd1);
        chk("ovf_causeWr",  32'(o_cw[0]),   32'd1);
        chk("ovf_epcWr",    32'(o_ew[0]),   32'd1);
        chk("ovf_epcValue", o_epc[0],       32'h0000_003C);
        chk("ovf_memAddr",  o_addr[0],      32'd254);
        chk("ovf_memRead",  32'(o_rd[0]),   32'd1);
        bcnt = int'(o_busy[0]);
        #1 t_ov[0] = 1'b0; t_ov[1] = 1'b0;
        @(negedge clk);
        chk("ovf_wait_pcWr", 32'(o_pw[0]), 32'd0);
        bcnt += int'(o_busy[0]);
        @(negedge clk);
        chk("ovf_pcWr",    32'(o_pw[0]), 32'd1);
        chk("ovf_pcValue", o_pcval[0],   32'h0000_007C);
        bcnt += int'(o_busy[0]);
        @(negedge clk);
        bcnt += int'(o_busy[0]);
        chk("ovf_busy_cycles", 32'(bcnt), 32'd3);
        repeat (4) @(negedge clk);

        // All three flags together: opcode wins, one sequence.
        #1 t_op[0] = 1'b1; t_ov[0] = 1'b1; t_dz[0] = 1'b1; snap = ob_pw[0];
        @(negedge clk);
        chk("sim_causeSel", 32'(o_csel[0]), 32'd0);
        chk("sim_memAddr",  o_addr[0],      32'd253);
        #1 t_op[0] = 1'b0; t_ov[0] = 1'b0; t_dz[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1 chk("sim_pcWr_pulses", 32'(ob_pw[0] - snap), 32'd1);

        // Divide-by-zero at PC 0, latency 3.
        t_dz[1] = 1'b1; t_pc[1] = 32'd0; t_md[1] = 8'hA0;
        @(negedge clk);
        chk("dz_causeSel", 32'(o_csel[1]), 32'd2);
        chk("dz_epcValue", o_epc[1],       32'hFFFF_FFFC);
        chk("dz_memAddr",  o_addr[1],      32'd255);
        #1 t_dz[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dz_wait_memRead", 32'(o_rd[1]), 32'd1);
            chk("dz_wait_pcWr",    32'(o_pw[1]), 32'd0);
        end
        @(negedge clk);
        chk("dz_pcWr",    32'(o_pw[1]), 32'd1);
        chk("dz_pcValue", o_pcval[1],   32'h0000_00A0);

        // Overflow pulse during the wait of an opcode exception is ignored.
        @(negedge clk);
        #1 t_op[1] = 1'b1; snap = ob_cw[1];
        @(negedge clk);
        #1 t_op[1] = 1'b0;
        @(negedge clk);
        #1 t_ov[1] = 1'b1;
        @(negedge clk);
        chk("msk_causeSel_wait", 32'(o_csel[1]), 32'd0);
        #1 t_ov[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("msk_causeSel_end", 32'(o_csel[1]), 32'd0);
        #1 chk("msk_causeWr_pulses", 32'(ob_cw[1] - snap), 32'd1);

        // Reset asserted in the middle of the wait.
        @(negedge clk);
        #1 t_ov[1] = 1'b1; snap = ob_pw[1];
        @(negedge clk);
        #1 t_ov[1] = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rmw_busy",    32'(o_busy[1]), 32'd0);
        chk("rmw_memRead", 32'(o_rd[1]),   32'd0);
        chk("rmw_pcWr",    32'(o_pw[1]),   32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rmw_idle_busy", 32'(o_busy[1]), 32'd0);
        end
        #1 chk("rmw_pcWr_pulses", 32'(ob_pw[1] - snap), 32'd0);

        // Random flags, PCs, memory bytes and occasional resets.
        repeat (600) begin
            @(negedge clk);
            #1;
            reset = ($urandom_range(0, 99) != 0);
            for (int d = 0; d < 2; d++) begin
                f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                t_op[d] = f[0];
                t_ov[d] = f[1];
                t_dz[d] = f[2];
                t_pc[d] = $urandom;
                t_md[d] = 8'($urandom_range(0, 255));
            end
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            t_op[d] = 1'b0; t_ov[d] = 1'b0; t_dz[d] = 1'b0;
        end
        repeat (8) @(negedge clk);
        #1;
        chk("rnd_l1_causeWr_count", 32'(ob_cw[0]), 32'(m_nexc[0]));
        chk("rnd_l3_causeWr_count", 32'(ob_cw[1]), 32'(m_nexc[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Multi-cycle sequencer for exception entry in the multicycle CPU.
- On an exception flag it:
  - selects the cause code through the 3-input cause mux (causeSel = that mux's 2-bit select)
  - writes Cause and EPC
  - reads the 8-bit handler vector byte from memory
  - loads PC with the zero-extended vector.
- Sits beside the main control unit. Main control stalls while busy=1.

Parameters:
- MEM_LATENCY, 1, cycles from memRead assertion to memData valid (1..7).
- VEC_OPCODE, 253, byte address of the invalid-opcode handler vector.
- VEC_OVERFLOW, 254, byte address of the overflow handler vector.
- VEC_DIVZERO, 255, byte address of the divide-by-zero handler vector.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- excOpcode  input  1  invalid-opcode flag from control (level, sampled in IDLE).
- excOverflow  input  1  ALU overflow flag.
- excDivZero  input  1  divide-by-zero flag from the div unit.
- pcCurrent  input  32  PC value at detection (already PC+4).
- memData  input  8  byte returned by memory.
- causeSel  output  2  cause-mux select. 00=opcode, 01=overflow, 10=divzero. Registered.
- causeWrite  output  1  Cause register write enable.
- epcWrite  output  1  EPC register write enable.
- epcValue  output  32  value to write to EPC.
- memRead  output  1  memory read request.
- memAddr  output  32  memory byte address.
- pcWrite  output  1  PC write enable.
- pcValue  output  32  new PC value.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including causeSel=00 and all 32-bit outputs.
  - Internal latches (cause, PC, data, wait counter) cleared.
- Reset mid-sequence: abort immediately to IDLE. No partial write completes after reset asserts.
- States: IDLE, SAVE, WAIT, LOAD. All outputs are registered.
- IDLE:
  - If any exc flag is 1 at a rising edge:
    - Latch the winning cause.
    - Latch pcCurrent.
    - Go to SAVE.
  - Priority: opcode > overflow > divzero. Simultaneous flags take the highest priority; the rest are dropped, not queued.
- SAVE (exactly 1 cycle):
  - causeSel=latched code.
  - causeWrite=1, epcWrite=1.
  - epcValue = latched PC - 4, modulo 2^32 (0x00000000 -> 0xFFFFFFFC).
  - memRead=1, memAddr=vector of the cause.
  - Load the wait counter with MEM_LATENCY.
  - Next state WAIT.
- WAIT:
  - memRead=1, memAddr held. causeWrite=0, epcWrite=0.
  - Stays exactly MEM_LATENCY cycles.
  - memData is captured at the rising edge that ends the last WAIT cycle.
  - Next state LOAD.
- LOAD (1 cycle):
  - pcWrite=1, pcValue = {24'b0, captured byte}.
  - memRead=0.
  - Next state IDLE.
- causeSel holds its last value after the sequence ends. memAddr and pcValue return to 0 in IDLE.
- Exc flags are ignored while busy=1. A flag still high on return to IDLE starts a new sequence; de-asserting the flag is the control unit's responsibility.
- Latency:
  - Flag sampled at edge N.
  - SAVE occupies cycle N+1.
  - pcWrite is high in cycle N+2+MEM_LATENCY.
  - busy is high for 2+MEM_LATENCY cycles.
- Each write enable (causeWrite, epcWrite, pcWrite) is high for exactly one cycle per exception.

Test Plan:
- Reset: hold reset=0 for 3 cycles with excOverflow=1 -> all outputs 0, busy=0. Release reset -> the sequence begins at the next edge.
- Single overflow, MEM_LATENCY=1, pcCurrent=0x00000040, memData=0x7C:
  - Next cycle: causeSel=01, causeWrite=epcWrite=1, epcValue=0x0000003C, memAddr=254, memRead=1.
  - After 1 WAIT cycle: pcWrite=1, pcValue=0x0000007C.
  - busy high for 3 cycles.
- Simultaneous excOpcode=excOverflow=excDivZero=1 -> causeSel=00, memAddr=253. Exactly one sequence, one pcWrite pulse.
- Div-zero with MEM_LATENCY=3, pcCurrent=0x00000000, memData=0xA0:
  - epcValue=0xFFFFFFFC, memAddr=255.
  - WAIT lasts 3 cycles; pcValue=0x000000A0 in cycle N+5.
- Busy masking: excOverflow pulses during WAIT of an opcode exception -> ignored. causeSel stays 00 and only one causeWrite pulse occurs.
- Reset mid-WAIT: assert reset=0 during WAIT -> busy and memRead drop immediately, no pcWrite pulse. After release with no flags -> stays IDLE.
